// File: rtl/pipelined_rca.sv
// pipelined_rca: STAGES-deep ripple-carry adder, one SLICE-bit slice per stage, valid/ready flow.
// Define PIPELINED_RCA_OVF_FLAG_EN to add the signed-overflow output ovf, aligned with sum.

module rca_stage #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
endmodule

module pipelined_rca #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef PIPELINED_RCA_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0]            vld_pipe, v_src, c_src, c_nxt, c_q;
    logic [STAGES:0]              rdy;
    logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src, s_nxt, a_q, b_q, s_q;
    logic [STAGES-1:0][SLICE-1:0] sl_sum;

    // Stage k consumes the registers of stage k-1; stage 0 consumes the input port.
    always_comb begin
        v_src[0] = in_valid;
        a_src[0] = a;
        b_src[0] = b;
        s_src[0] = '0;
        c_src[0] = cin;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = vld_pipe[k-1];
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
        end
    end

    // A stage loads when empty or when it drains this cycle, so bubbles collapse.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = LAST; k >= 0; k--)
            rdy[k] = !vld_pipe[k] || rdy[k+1];
    end

    assign in_ready = rdy[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        rca_stage #(.SLICE(SLICE)) u_stage (
            .a    (a_src[g][g*SLICE +: SLICE]),
            .b    (b_src[g][g*SLICE +: SLICE]),
            .cin  (c_src[g]),
            .s    (sl_sum[g]),
            .cout (c_nxt[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k] = s_src[k];
            s_nxt[k][k*SLICE +: SLICE] = sl_sum[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (rdy[k]) vld_pipe[k] <= v_src[k];
        end
    end

    // Datapath of an empty stage is don't-care, so only the valid bits are reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_nxt[k];
                c_q[k] <= c_nxt[k];
            end
        end
    end

    assign out_valid = vld_pipe[LAST];
    assign sum       = out_valid ? s_q[LAST] : '0;
    assign cout      = out_valid & c_q[LAST];

`ifdef PIPELINED_RCA_OVF_FLAG_EN
    assign ovf = out_valid
               & (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
               & (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed steps plus random traffic, scored against an arithmetic queue model.
`timescale 1ns/1ps
module tb_pipelined_rca;
    localparam int W  = 32;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst_n, cin, in_valid, in_ready, cout, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
`ifdef PIPELINED_RCA_OVF_FLAG_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    logic [W+1:0] exp_q[$];   // {ovf, cout, sum} per accepted operation

    always #5 clk = ~clk;

    pipelined_rca #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef PIPELINED_RCA_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint u, s;
        logic   v;
        u = longint'(x) + longint'(y) + longint'(c);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {v, u[W], u[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: score handshakes at the negedge, then return just after the next posedge.
    task automatic tick();
        logic [W+1:0] e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_sum", 64'(sum), 64'(e[W-1:0]));
                check("sb_cout", 64'(cout), 64'(e[W]));
`ifdef PIPELINED_RCA_OVF_FLAG_EN
                check("sb_ovf", 64'(ovf), 64'(e[W+1]));
`endif
            end
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
        int i;
        i = 0;
        while (!out_valid && i < 20) begin
            tick();
            i++;
        end
        check({tag, "_vld"}, 64'(out_valid), 64'(1));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef PIPELINED_RCA_OVF_FLAG_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo) i = 0;
`endif
        tick();
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 64) begin
            tick();
            i++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [W+1:0] e;
        int n0, pick;

        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Basic sum and exact latency
        a = 32'h001F001F; b = 32'h0006000C; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= ST; i++) begin
            check("lat_vld", 64'(out_valid), 64'(i == ST));
            if (i < ST) tick();
        end
        check("lat_sum", 64'(sum), 64'(32'h0025002B));
        check("lat_cout", 64'(cout), 64'(0));
        tick();

        // Carry ripple across every slice boundary
        send(32'hFFFFFFFF, 32'h0, 1'b1);
        expect_out("wrap1", 32'h0, 1'b1, 1'b0);
        send(32'hFFFFFFFF, 32'h0, 1'b0);
        expect_out("wrap0", 32'hFFFFFFFF, 1'b0, 1'b0);

        // Back-to-back throughput: i+i for i=1..8
        for (int t = 0; t < 13; t++) begin
            in_valid = (t < 8);
            a = W'(t + 1); b = W'(t + 1); cin = 1'b0;
            if (t < 8) check("b2b_in_ready", 64'(in_ready), 64'(1));
            check("b2b_vld", 64'(out_valid), 64'(t >= 4 && t < 12));
            if (t >= 4 && t < 12) check("b2b_sum", 64'(sum), 64'(2 * (t - 3)));
            tick();
        end
        in_valid = 1'b0;

        // Stall: only STAGES operations fit, output frozen, then drains in order
        out_ready = 1'b0;
        n0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("stall_acc", 64'(n_acc - n0), 64'(ST));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        e = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            check("stall_vld", 64'(out_valid), 64'(1));
            check("stall_sum", 64'(sum), 64'(e[W-1:0]));
            check("stall_cout", 64'(cout), 64'(e[W]));
            tick();
        end
        out_ready = 1'b1;
        drain("stall_drain");

        // Reset with operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        tick();
        tick();
        check("pre_rst_vld", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 64'(out_valid), 64'(0));
        check("mid_rst_sum", 64'(sum), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 8; i++) begin
            check("post_rst_vld", 64'(out_valid), 64'(0));
            tick();
        end

`ifdef PIPELINED_RCA_OVF_FLAG_EN
        send(32'h7FFFFFFF, 32'h1, 1'b0);
        expect_out("ovf", 32'h80000000, 1'b0, 1'b1);
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 3);
            a = (pick == 0) ? 32'hFFFFFFFF : $urandom;
            b = (pick == 1) ? 32'h7FFFFFFF : $urandom;
            cin = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES, and SLICE = WIDTH/STAGES.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 a  input  WIDTH  operand A, sampled on input handshake.
REQ-006 b  input  WIDTH  operand B, sampled on input handshake.
REQ-007 cin  input  1  carry-in, sampled on input handshake.
REQ-008 in_valid  input  1  producer presents a, b and cin.
REQ-009 in_ready  output  1  block accepts an operation this cycle.
REQ-010 sum  output  WIDTH  result, (a + b + cin) mod 2^WIDTH.
REQ-011 cout  output  1  carry out of bit WIDTH-1.
REQ-012 out_valid  output  1  sum and cout hold a valid result.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 ovf  output  1  signed overflow flag; present only with OVF_FLAG_EN.

Function
REQ-015 Input handshake SHALL occur on a cycle where in_valid and in_ready are both 1; output handshake SHALL occur where out_valid and out_ready are both 1.
REQ-016 Stage k (0..STAGES-1) SHALL add bits [k*SLICE +: SLICE] using the carry registered by stage k-1; stage 0 SHALL use the accepted cin.
REQ-017 Bits above the active slice SHALL be delayed alongside the operation; completed low sum slices SHALL travel with it.
REQ-018 With out_ready held at 1, latency from input handshake to out_valid SHALL be exactly STAGES cycles.
REQ-019 With out_ready held at 1, the block SHALL accept one operation per cycle and in_ready SHALL stay at 1.
REQ-020 Each stage SHALL carry a valid bit, and a stage SHALL load when it is empty or when its contents move downstream in the same cycle.
REQ-021 Bubbles SHALL collapse, so that a stalled output never blocks empty upstream stages from filling.
REQ-022 in_ready SHALL be 1 when stage 0 is empty or stage 0 advances this cycle; in_ready SHALL combinationally depend on out_ready.
REQ-023 While out_valid=1 and out_ready=0, sum, cout, ovf and out_valid SHALL hold stable.
REQ-024 Results SHALL emerge in acceptance order, with none dropped or duplicated.
REQ-025 When all STAGES stages are full and out_ready=0, in_ready SHALL be 0.
REQ-026 A simultaneous input and output handshake on a full pipeline SHALL be accepted without loss.
REQ-027 Carry wrap SHALL be handled as follows: an all-ones operand plus cin=1 SHALL ripple across every slice boundary to produce sum=0 and cout=1.
REQ-028 Datapath registers of empty stages SHALL be don't-care; only valid bits SHALL be reset.

Reset
REQ-029 While rst_n=0, all stage valid bits SHALL be 0, out_valid SHALL be 0, and sum, cout and ovf SHALL be 0.
REQ-030 in_ready SHALL be 1 from the first rising edge after rst_n deasserts.
REQ-031 Assertion of rst_n mid-operation SHALL discard all in-flight operations, and none SHALL appear after release.

Configuration
REQ-032 Macro PIPELINED_RCA_OVF_FLAG_EN SHALL control the ovf port.
REQ-033 With the macro defined, port ovf SHALL exist and SHALL equal (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), aligned with sum; its latency SHALL be identical to sum.
REQ-034 Without the macro, port ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=32, STAGES=4)
REQ-035 Apply a=0x001F001F, b=0x0006000C, cin=0, with out_ready=1 -> sum=0x0025002B and cout=0, with out_valid exactly 4 cycles after acceptance.
REQ-036 Apply a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000 and cout=1; then apply cin=0 -> sum=0xFFFFFFFF and cout=0.
REQ-037 Drive 8 back-to-back operations i+i (i=1..8) with out_ready=1 -> sums 2,4,...,16 appear on 8 consecutive cycles and in_ready never drops.
REQ-038 Hold out_ready=0 and offer 6 operations -> exactly 4 are accepted, in_ready=0 afterwards, and the output stays frozen; then release out_ready -> all 4 results drain in order.
REQ-039 Pulse rst_n low with 3 operations in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-040 With the macro defined, apply a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1 and cout=0.
